// File: rtl/ysyx_23060077_sys_exu.sv
// ysyx_23060077_sys_exu: SYSTEM-opcode execution unit (CSR ops, ECALL, MRET).
// Three-state FSM IDLE -> EXEC -> RESP. The CSR file sees a single-cycle
// strobe in EXEC. The old CSR value is captured there and returned through a
// valid/ready writeback handshake in RESP.
// Optional feature: define YSYX_23060077_EBREAK_EN to add the halt_o output,
// which pulses in EXEC for EBREAK. Without it, EBREAK retires as a NOP.
module ysyx_23060077_sys_exu (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [2:0]  in_funct3,
    input  logic [11:0] in_csr_addr,
    input  logic [4:0]  in_rs1_idx,
    input  logic [31:0] in_rs1_data,
    input  logic [4:0]  in_rd,
    output logic        sys,
    output logic [2:0]  funct3,
    output logic [11:0] csr_rd_addr,
    output logic [11:0] csr_wr_addr,
    output logic [31:0] csr_wr_data,
    output logic [31:0] csr_pc,
    output logic        csr_ecall_i,
    output logic        csr_mret_i,
    input  logic [31:0] csr_rd_data,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mpec,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_wdata,
`ifdef YSYX_23060077_EBREAK_EN
    output logic        out_wen,
    output logic        halt_o
`else
    output logic        out_wen
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [31:0] pc_q;
    logic [2:0]  funct3_q;
    logic [11:0] csr_addr_q;
    logic [4:0]  rs1_idx_q;
    logic [31:0] rs1_data_q;
    logic [4:0]  rd_q;
    logic [31:0] wdata_q;
    logic        wen_q;

    logic        exec_act;
    logic        resp_act;
    logic        is_csr_op;
    logic        is_ecall;
    logic        is_mret;

    // Outputs are held at zero while reset is high. An in-flight EXEC then
    // cannot fire a strobe in the cycle it is being dropped.
    assign exec_act  = (state_q == EXEC) && !reset;
    assign resp_act  = (state_q == RESP) && !reset;

    // CSR ops are exactly the funct3 codes whose low two bits are non-zero.
    assign is_csr_op = (funct3_q[1:0] != 2'b00);
    assign is_ecall  = (funct3_q == 3'b000) && (csr_addr_q == 12'h000);
    assign is_mret   = (funct3_q == 3'b000) && (csr_addr_q == 12'h302);

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one EXEC cycle, then hold RESP until the consumer is ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the instruction fields on acceptance.
    always_ff @(posedge clock) begin
        if (in_valid && in_ready) begin
            pc_q       <= in_pc;
            funct3_q   <= in_funct3;
            csr_addr_q <= in_csr_addr;
            rs1_idx_q  <= in_rs1_idx;
            rs1_data_q <= in_rs1_data;
            rd_q       <= in_rd;
        end
    end

    // Capture the pre-update CSR value and the writeback enable during EXEC.
    always_ff @(posedge clock) begin
        if (state_q == EXEC) begin
            wdata_q <= csr_rd_data;
            wen_q   <= is_csr_op && (rd_q != 5'd0);
        end
    end

    // CSR-file, redirect and writeback drives; everything is zero outside its own state.
    always_comb begin
        in_ready       = (state_q == IDLE);
        sys            = exec_act;
        funct3         = 3'b000;
        csr_rd_addr    = 12'h000;
        csr_wr_addr    = 12'h000;
        csr_wr_data    = 32'h0;
        csr_pc         = 32'h0;
        csr_ecall_i    = 1'b0;
        csr_mret_i     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_valid      = resp_act;
        out_rd         = 5'd0;
        out_wdata      = 32'h0;
        out_wen        = 1'b0;
        if (exec_act) begin
            funct3      = funct3_q;
            csr_rd_addr = csr_addr_q;
            csr_wr_addr = csr_addr_q;
            csr_wr_data = funct3_q[2] ? {27'b0, rs1_idx_q} : rs1_data_q;
            csr_pc      = pc_q;
            csr_ecall_i = is_ecall;
            csr_mret_i  = is_mret;
            if (is_ecall) begin
                redirect_valid = 1'b1;
                redirect_pc    = csr_mtvec;
            end else if (is_mret) begin
                redirect_valid = 1'b1;
                redirect_pc    = csr_mpec;
            end
        end
        if (resp_act) begin
            out_rd    = rd_q;
            out_wdata = wdata_q;
            out_wen   = wen_q;
        end
    end

`ifdef YSYX_23060077_EBREAK_EN
    // EBREAK halt strobe, valid only in EXEC.
    always_comb begin
        halt_o = exec_act && (funct3_q == 3'b000) && (csr_addr_q == 12'h001);
    end
`endif

endmodule
